// File: rtl/bcd_cascade_timer.sv
// bcd_cascade_timer: cascade of per-digit modulo counters with up/down, preset, clear and stop-at-terminal.
module bcd_cascade_timer #(
  parameter int          DIGITS = 4,
  parameter logic [31:0] MODS   = 32'h0000_6A6A
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  up_dn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  stop_end,
  output logic [4*DIGITS-1:0]   cntr,
  output logic                  carry_o,
  output logic                  at_term,
  output logic                  done
);
  logic [DIGITS:0]     low_max, low_zero;
  logic [4*DIGITS-1:0] nxt, ld;
  logic                adv;
  assign low_max[0]  = 1'b1;
  assign low_zero[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    localparam logic [3:0] M = MODS[4*g+:4] - 4'd1;
    logic [3:0] d, lv;
    logic       is_max, is_zero, step;
    assign d                = cntr[4*g+:4];
    assign lv               = load_val[4*g+:4];
    assign is_max           = d == M;
    assign is_zero          = d == 4'd0;
    assign low_max[g+1]     = low_max[g] & is_max;
    assign low_zero[g+1]    = low_zero[g] & is_zero;
    assign step             = up_dn ? low_max[g] : low_zero[g];
    assign nxt[4*g+:4]      = !step ? d : up_dn ? (is_max ? 4'd0 : d + 4'd1) : (is_zero ? M : d - 4'd1);
    assign ld[4*g+:4]       = lv > M ? M : lv;
  end
  assign at_term = up_dn ? low_max[DIGITS] : low_zero[DIGITS];
  assign adv     = tick & ~clr & ~load & ~(stop_end & at_term);
  assign carry_o = tick & at_term & ~stop_end & ~clr & ~load;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntr <= '0;
      done <= 1'b0;
    end else if (clr) begin
      cntr <= '0;
      done <= 1'b0;
    end else if (load) begin
      cntr <= ld;
      done <= 1'b0;
    end else begin
      if (adv) cntr <= nxt;
      if (tick && at_term) done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bcd_cascade_timer.sv
// tb_bcd_cascade_timer: directed checks of the digit cascade, presets, stop mode, reset and chaining.
module tb_bcd_cascade_timer;
  logic        clk = 1'b0, rst = 1'b1, tick = 1'b0, up_dn = 1'b1, clr = 1'b0, load = 1'b0, stop_end = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] cntr;
  logic        carry_o, at_term, done;
  logic        ctick = 1'b0, cload = 1'b0;
  logic [15:0] clv_lo = '0, lo_cntr;
  logic [7:0]  clv_hi = '0, hi_cntr;
  logic        lo_carry, lo_term, lo_done, hi_carry, hi_term, hi_done;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  bcd_cascade_timer dut (
    .clk(clk), .rst(rst), .tick(tick), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .stop_end(stop_end), .cntr(cntr), .carry_o(carry_o),
    .at_term(at_term), .done(done)
  );

  bcd_cascade_timer u_lo (
    .clk(clk), .rst(rst), .tick(ctick), .up_dn(1'b1), .clr(1'b0), .load(cload),
    .load_val(clv_lo), .stop_end(1'b0), .cntr(lo_cntr), .carry_o(lo_carry),
    .at_term(lo_term), .done(lo_done)
  );

  bcd_cascade_timer #(.DIGITS(2), .MODS(32'h0000_0042)) u_hi (
    .clk(clk), .rst(rst), .tick(lo_carry), .up_dn(1'b1), .clr(1'b0), .load(cload),
    .load_val(clv_hi), .stop_end(1'b0), .cntr(hi_cntr), .carry_o(hi_carry),
    .at_term(hi_term), .done(hi_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mmss(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  initial begin
    cyc();
    chk("rst_cntr", 32'(cntr), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_term_up", 32'(at_term), 32'h0);
    up_dn = 1'b0;
    #1 chk("rst_term_dn", 32'(at_term), 32'h1);
    up_dn = 1'b1;
    cyc();
    rst = 1'b0;
    chk("pre_done", 32'(done), 32'h0);
    // full 59:59 up run with wrap
    for (int n = 0; n < 3600; n++) begin
      tick = 1'b1;
      #1 chk("carry_up", 32'(carry_o), 32'(n == 3599));
      cyc();
      chk("cnt_up", 32'(cntr), 32'(mmss((n + 1) % 3600)));
    end
    tick = 1'b0;
    chk("up_done", 32'(done), 32'h1);
    // countdown from 01:30 with stop at zero
    load = 1'b1; load_val = 16'h0130; up_dn = 1'b0; stop_end = 1'b1;
    cyc();
    load = 1'b0;
    chk("dn_load", 32'(cntr), 32'h0130);
    chk("dn_load_done", 32'(done), 32'h0);
    for (int k = 0; k < 90; k++) begin
      tick = 1'b1;
      #1 chk("carry_dn", 32'(carry_o), 32'h0);
      cyc();
      chk("cnt_dn", 32'(cntr), 32'(mmss(89 - k)));
    end
    chk("dn_zero_done", 32'(done), 32'h0);
    chk("dn_zero_term", 32'(at_term), 32'h1);
    chk("dn_hold_carry", 32'(carry_o), 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("dn_hold", 32'(cntr), 32'h0);
      chk("dn_hold_done", 32'(done), 32'h1);
    end
    stop_end = 1'b0;
    #1 chk("dn_wrap_carry", 32'(carry_o), 32'h1);
    cyc();
    tick = 1'b0;
    chk("dn_wrap", 32'(cntr), 32'h5959);
    // clamped preset
    load = 1'b1; load_val = 16'h7F9C; up_dn = 1'b1;
    cyc();
    load = 1'b0;
    chk("clamp", 32'(cntr), 32'h5959);
    chk("clamp_term", 32'(at_term), 32'h1);
    chk("clamp_done", 32'(done), 32'h0);
    tick = 1'b1;
    #1 chk("clamp_carry", 32'(carry_o), 32'h1);
    cyc();
    tick = 1'b0;
    chk("clamp_wrap", 32'(cntr), 32'h0);
    chk("clamp_wrap_done", 32'(done), 32'h1);
    // priority: clr > load > tick
    load = 1'b1; load_val = 16'h5959; stop_end = 1'b1;
    cyc();
    load = 1'b0; tick = 1'b1;
    #1 chk("stop_up_carry", 32'(carry_o), 32'h0);
    cyc();
    chk("stop_up_hold", 32'(cntr), 32'h5959);
    chk("stop_up_done", 32'(done), 32'h1);
    clr = 1'b1; load = 1'b1; load_val = 16'h0123;
    #1 chk("clr_carry", 32'(carry_o), 32'h0);
    cyc();
    clr = 1'b0; load = 1'b0; tick = 1'b0;
    chk("clr_cntr", 32'(cntr), 32'h0);
    chk("clr_done", 32'(done), 32'h0);
    load = 1'b1; tick = 1'b1;
    cyc();
    load = 1'b0; tick = 1'b0; stop_end = 1'b0;
    chk("load_tick", 32'(cntr), 32'h0123);
    // async reset mid-count at 34:58 with done set
    load = 1'b1; load_val = 16'h5959;
    cyc();
    load = 1'b0; tick = 1'b1;
    repeat (2099) cyc();
    tick = 1'b0;
    chk("pre_rst_cnt", 32'(cntr), 32'h3458);
    chk("pre_rst_done", 32'(done), 32'h1);
    #2 rst = 1'b1;
    #1 chk("arst_cntr", 32'(cntr), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    rst = 1'b0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("post_rst", 32'(cntr), 32'h0001);
    // chained stages
    cload = 1'b1; clv_lo = 16'h5959; clv_hi = 8'h00;
    cyc();
    cload = 1'b0;
    chk("ch_lo_ld", 32'(lo_cntr), 32'h5959);
    ctick = 1'b1;
    #1 chk("ch_lo_carry", 32'(lo_carry), 32'h1);
    chk("ch_hi_carry0", 32'(hi_carry), 32'h0);
    cyc();
    chk("ch_lo_wrap", 32'(lo_cntr), 32'h0);
    chk("ch_hi_step", 32'(hi_cntr), 32'h01);
    #1 chk("ch_lo_nocarry", 32'(lo_carry), 32'h0);
    cyc();
    ctick = 1'b0;
    chk("ch_lo_1", 32'(lo_cntr), 32'h0001);
    chk("ch_hi_hold", 32'(hi_cntr), 32'h01);
    cload = 1'b1; clv_lo = 16'h5959; clv_hi = 8'hFF;
    cyc();
    cload = 1'b0;
    chk("ch_hi_clamp", 32'(hi_cntr), 32'h31);
    chk("ch_hi_term", 32'(hi_term), 32'h1);
    ctick = 1'b1;
    #1 chk("ch_hi_carry", 32'(hi_carry), 32'h1);
    cyc();
    ctick = 1'b0;
    chk("ch_all_lo", 32'(lo_cntr), 32'h0);
    chk("ch_all_hi", 32'(hi_cntr), 32'h0);
    chk("ch_hi_done", 32'(hi_done), 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
